// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if
//   Bundles the two requester handshakes, the response handshake and the busy
//   flag of alu_arbiter.
//   master : requester/consumer side (drives reqN_valid/op/a/b and rsp_ready)
//   slave  : arbiter side (drives reqN_ready, rsp_valid/id/data/err, busy)
interface alu_arbiter_if #(
    parameter int WIDTH    = 15,
    parameter int OP_WIDTH = 3
);
    logic                req0_valid;
    logic                req0_ready;
    logic [OP_WIDTH-1:0] req0_op;
    logic [WIDTH-1:0]    req0_a;
    logic [WIDTH-1:0]    req0_b;

    logic                req1_valid;
    logic                req1_ready;
    logic [OP_WIDTH-1:0] req1_op;
    logic [WIDTH-1:0]    req1_a;
    logic [WIDTH-1:0]    req1_b;

    logic                rsp_valid;
    logic                rsp_ready;
    logic                rsp_id;
    logic [WIDTH:0]      rsp_data;
    logic                rsp_err;
    logic                busy;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_data, rsp_err, busy
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_data, rsp_err, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one combinational alu between two requesters. Round-robin grant in
//   IDLE, operands latched on accept, result registered at the end of EXEC and
//   held in RESP until the consumer takes it.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : alu_arbiter_if.slave (request ports 0/1, response, busy)
//
// alu
//   Combinational datapath: 001 ADD (carry kept in bit WIDTH), 010 SUB
//   (modulo 2^(WIDTH+1)), 011 AND, 100 OR, 101 XOR; any other opcode yields 0.
module alu #(
    parameter int WIDTH    = 15,
    parameter int OP_WIDTH = 3
) (
    input  logic [OP_WIDTH-1:0] op_i,
    input  logic [WIDTH-1:0]    a_i,
    input  logic [WIDTH-1:0]    b_i,
    output logic [WIDTH:0]      y_o
);
    logic [WIDTH:0] a_ext;
    logic [WIDTH:0] b_ext;

    assign a_ext = {1'b0, a_i};
    assign b_ext = {1'b0, b_i};

    always_comb begin
        y_o = '0;
        case (op_i)
            OP_WIDTH'(1): y_o = a_ext + b_ext;
            OP_WIDTH'(2): y_o = a_ext - b_ext;
            OP_WIDTH'(3): y_o = a_ext & b_ext;
            OP_WIDTH'(4): y_o = a_ext | b_ext;
            OP_WIDTH'(5): y_o = a_ext ^ b_ext;
            default:      y_o = '0;
        endcase
    end
endmodule

module alu_arbiter #(
    parameter int WIDTH    = 15,
    parameter int OP_WIDTH = 3
) (
    input logic         clk,
    input logic         rst_n,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t              state_q;
    logic                rr_q;
    logic                id_q;
    logic                rsp_valid_q;
    logic                rsp_err_q;
    logic [WIDTH:0]      rsp_data_q;
    logic [OP_WIDTH-1:0] op_q;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;

    logic                gnt_any;
    logic                gnt_id;
    logic [WIDTH:0]      alu_y;

    function automatic logic op_illegal(input logic [OP_WIDTH-1:0] op);
        return !((op >= OP_WIDTH'(1)) && (op <= OP_WIDTH'(5)));
    endfunction

    // Grant is only offered in IDLE and never while reset is held, so a
    // requester cannot see ready during reset.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = 1'b0;
        if ((state_q == IDLE) && rst_n) begin
            if (bus.req0_valid && bus.req1_valid) begin
                gnt_any = 1'b1;
                gnt_id  = rr_q;
            end else if (bus.req0_valid) begin
                gnt_any = 1'b1;
                gnt_id  = 1'b0;
            end else if (bus.req1_valid) begin
                gnt_any = 1'b1;
                gnt_id  = 1'b1;
            end
        end
    end

    assign bus.req0_ready = gnt_any && !gnt_id;
    assign bus.req1_ready = gnt_any && gnt_id;

    // Operand registers carry no reset: they are only observed through the
    // alu while in EXEC, which is always preceded by an accept.
    always_ff @(posedge clk) begin
        if (gnt_any) begin
            op_q <= gnt_id ? bus.req1_op : bus.req0_op;
            a_q  <= gnt_id ? bus.req1_a  : bus.req0_a;
            b_q  <= gnt_id ? bus.req1_b  : bus.req0_b;
        end
    end

    alu #(
        .WIDTH   (WIDTH),
        .OP_WIDTH(OP_WIDTH)
    ) u_alu (
        .op_i(op_q),
        .a_i (a_q),
        .b_i (b_q),
        .y_o (alu_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_q        <= 1'b0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_any) begin
                        id_q    <= gnt_id;
                        // Point at the other port so contention alternates.
                        rr_q    <= ~gnt_id;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_err_q   <= op_illegal(op_q);
                    rsp_data_q  <= op_illegal(op_q) ? '0 : alu_y;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed scenarios plus randomized traffic, all
// checked against a transaction-level reference model kept in this file.
module tb_alu_arbiter;
    localparam int W  = 15;
    localparam int OW = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    alu_arbiter_if #(.WIDTH(W), .OP_WIDTH(OW)) bus ();

    alu_arbiter #(.WIDTH(W), .OP_WIDTH(OW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Requester-side stimulus
    bit          d_v  [2];
    logic [2:0]  d_op [2];
    logic [14:0] d_a  [2];
    logic [14:0] d_b  [2];
    bit          d_rdy;

    // Reference model: is the arbiter free, computing, or holding a response
    bit m_idle = 1'b1;
    bit m_exec = 1'b0;
    bit m_rsp  = 1'b0;
    bit m_rr   = 1'b0;
    int e_id, e_data, e_err;

    bit last_g_any;
    bit last_g;
    bit last_obs_g;
    int n_acc;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_res(input int op, input int a, input int b);
        case (op)
            1: return (a + b) % 65536;
            2: return (a - b + 65536) % 65536;
            3: return a & b;
            4: return a | b;
            5: return a ^ b;
            default: return 0;
        endcase
    endfunction

    function automatic int rnd_opnd();
        if ($urandom_range(0, 3) == 0) return 32'h7FFF;
        return int'($urandom_range(0, 32767));
    endfunction

    // One clock cycle, entered and left just after a falling edge.
    task automatic cycle(input string tag);
        bit g_any;
        bit g;
        bus.req0_valid = d_v[0];
        bus.req0_op    = d_op[0];
        bus.req0_a     = d_a[0];
        bus.req0_b     = d_b[0];
        bus.req1_valid = d_v[1];
        bus.req1_op    = d_op[1];
        bus.req1_a     = d_a[1];
        bus.req1_b     = d_b[1];
        bus.rsp_ready  = d_rdy;
        #1;
        g_any = m_idle && (d_v[0] || d_v[1]);
        g     = (d_v[0] && d_v[1]) ? m_rr : (d_v[1] && !d_v[0]);
        chk({tag, ".rdy0"}, int'(bus.req0_ready), int'(g_any && !g));
        chk({tag, ".rdy1"}, int'(bus.req1_ready), int'(g_any && g));
        if (bus.req0_ready || bus.req1_ready) n_acc++;
        last_obs_g = bus.req1_ready;
        last_g_any = g_any;
        last_g     = g;
        if (g_any) begin
            e_id   = int'(g);
            e_err  = (int'(d_op[g]) >= 1 && int'(d_op[g]) <= 5) ? 0 : 1;
            e_data = ref_res(int'(d_op[g]), int'(d_a[g]), int'(d_b[g]));
            m_rr   = !g;
            m_idle = 1'b0;
            m_exec = 1'b1;
        end else if (m_exec) begin
            m_exec = 1'b0;
            m_rsp  = 1'b1;
        end else if (m_rsp && d_rdy) begin
            m_rsp  = 1'b0;
            m_idle = 1'b1;
        end
        @(negedge clk);
        chk({tag, ".rsp_valid"}, int'(bus.rsp_valid), int'(m_rsp));
        chk({tag, ".busy"}, int'(bus.busy), int'(!m_idle));
        if (m_rsp) begin
            chk({tag, ".rsp_id"},   int'(bus.rsp_id),   e_id);
            chk({tag, ".rsp_data"}, int'(bus.rsp_data), e_data);
            chk({tag, ".rsp_err"},  int'(bus.rsp_err),  e_err);
        end
    endtask

    task automatic drain();
        d_v[0] = 1'b0;
        d_v[1] = 1'b0;
        d_rdy  = 1'b1;
        repeat (4) cycle("drain");
    endtask

    // Issue one request on port p, consume its response and compare the
    // result against the constant the operation must produce.
    task automatic send(input int p, input int op, input int a, input int b,
                        input int exp_data, input int exp_err, input string tag);
        bit seen = 1'b0;
        d_v[p]  = 1'b1;
        d_op[p] = 3'(op);
        d_a[p]  = 15'(a);
        d_b[p]  = 15'(b);
        d_rdy   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle(tag);
            if (last_g_any && (int'(last_g) == p)) d_v[p] = 1'b0;
            if (m_rsp && !seen) begin
                seen = 1'b1;
                chk({tag, ".const_data"}, int'(bus.rsp_data), exp_data);
                chk({tag, ".const_err"},  int'(bus.rsp_err),  exp_err);
            end
            if (!d_v[p] && m_idle) break;
        end
    endtask

    // Assert reset in the middle of a cycle, after a grant to port p has
    // progressed `extra` cycles beyond the accept.
    task automatic reset_mid(input int p, input int extra, input string tag);
        d_v[p] = 1'b1; d_op[p] = 3'd1; d_a[p] = 15'h1234; d_b[p] = 15'h0101;
        d_rdy  = 1'b0;
        cycle({tag, ".acc"});
        d_v[p] = 1'b0;
        repeat (extra) cycle({tag, ".run"});
        d_v[0] = 1'b1;
        d_v[1] = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk({tag, ".rst_rsp_valid"}, int'(bus.rsp_valid), 0);
        chk({tag, ".rst_rsp_id"},    int'(bus.rsp_id),    0);
        chk({tag, ".rst_rsp_data"},  int'(bus.rsp_data),  0);
        chk({tag, ".rst_rsp_err"},   int'(bus.rsp_err),   0);
        chk({tag, ".rst_busy"},      int'(bus.busy),      0);
        chk({tag, ".rst_rdy0"},      int'(bus.req0_ready), 0);
        chk({tag, ".rst_rdy1"},      int'(bus.req1_ready), 0);
        @(negedge clk);
        rst_n  = 1'b1;
        m_idle = 1'b1; m_exec = 1'b0; m_rsp = 1'b0; m_rr = 1'b0;
        // Both ports valid right after release: port 0 must win (rr back at 0)
        d_rdy = 1'b1;
        cycle({tag, ".post"});
        chk({tag, ".post_grant"}, int'(last_obs_g), 0);
        if (last_g_any) d_v[last_g] = 1'b0;
        drain();
    endtask

    initial begin
        d_v[0] = 1'b0; d_v[1] = 1'b1; d_rdy = 1'b0;
        for (int p = 0; p < 2; p++) begin
            d_op[p] = 3'd1; d_a[p] = '0; d_b[p] = '0;
        end
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; bus.rsp_ready = 1'b1;
        bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0;

        // Power-up reset
        #1 rst_n = 1'b0;
        #1;
        chk("por.rsp_valid", int'(bus.rsp_valid), 0);
        chk("por.rsp_id",    int'(bus.rsp_id),    0);
        chk("por.rsp_data",  int'(bus.rsp_data),  0);
        chk("por.rsp_err",   int'(bus.rsp_err),   0);
        chk("por.busy",      int'(bus.busy),      0);
        chk("por.rdy0",      int'(bus.req0_ready), 0);
        chk("por.rdy1",      int'(bus.req1_ready), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        d_v[1] = 1'b0;

        // Contention: both ports always valid, grants must alternate 0,1,0,1
        begin
            int k = 0;
            for (int p = 0; p < 2; p++) begin
                d_v[p] = 1'b1; d_op[p] = 3'd1;
                d_a[p] = 15'(100 * (p + 1)); d_b[p] = 15'(p + 1);
            end
            d_rdy = 1'b1;
            n_acc = 0;
            for (int i = 0; i < 12; i++) begin
                cycle("cont");
                if (last_g_any) begin
                    chk("cont.order", int'(last_obs_g), k % 2);
                    k++;
                    d_op[last_g] = 3'($urandom_range(1, 5));
                    d_a[last_g]  = 15'(1000 * k + int'(last_g));
                    d_b[last_g]  = 15'(k);
                end
            end
            chk("cont.throughput", n_acc, 4);
            drain();
        end

        // Single request and width boundaries
        send(0, 1, 3, 5, 32'h0008, 0, "single");
        send(0, 1, 32'h7FFF, 32'h7FFF, 32'hFFFE, 0, "add_max");
        send(1, 2, 3, 5, 32'hFFFE, 0, "sub_wrap");
        send(0, 5, 32'h7FFF, 32'h0001, 32'h7FFE, 0, "xor");
        send(1, 3, 32'h5A5A, 32'h0FF0, 32'h0A50, 0, "and");
        send(0, 4, 32'h5000, 32'h000A, 32'h500A, 0, "or");
        send(0, 7, 32'h1234, 32'h4321, 0, 1, "ill7");
        send(1, 0, 32'h7FFF, 32'h7FFF, 0, 1, "ill0");

        // Backpressure with port 1 waiting
        d_v[0] = 1'b1; d_op[0] = 3'd2; d_a[0] = 15'h0400; d_b[0] = 15'h0001;
        d_rdy  = 1'b0;
        cycle("bp.acc0");
        d_v[0] = 1'b0;
        d_v[1] = 1'b1; d_op[1] = 3'd1; d_a[1] = 15'h0011; d_b[1] = 15'h0022;
        repeat (12) cycle("bp.hold");
        d_rdy = 1'b1;
        cycle("bp.consume");
        cycle("bp.acc1");
        chk("bp.grant1", int'(last_obs_g), 1);
        d_v[1] = 1'b0;
        repeat (2) cycle("bp.rsp1");
        drain();

        // One-cycle request pulse on port 0 while busy must be dropped
        d_v[1] = 1'b1; d_op[1] = 3'd4; d_a[1] = 15'h0F00; d_b[1] = 15'h00F0;
        cycle("cancel.acc1");
        d_v[1] = 1'b0;
        d_v[0] = 1'b1; d_op[0] = 3'd1; d_a[0] = 15'h0001; d_b[0] = 15'h0001;
        cycle("cancel.pulse");
        d_v[0] = 1'b0;
        drain();

        // Reset during EXEC and during RESP
        reset_mid(0, 0, "rst_exec");
        reset_mid(1, 1, "rst_resp");

        // Randomized traffic with cancels and backpressure
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (d_v[p]) begin
                    if ($urandom_range(0, 7) == 0) d_v[p] = 1'b0;
                end else if ($urandom_range(0, 1) == 1) begin
                    d_v[p]  = 1'b1;
                    d_op[p] = 3'($urandom_range(0, 7));
                    d_a[p]  = 15'(rnd_opnd());
                    d_b[p]  = 15'(rnd_opnd());
                end
            end
            d_rdy = ($urandom_range(0, 3) != 0);
            cycle("rand");
            if (last_g_any) d_v[last_g] = 1'b0;
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
